// File: rtl/xpmwrap_dpdistram_clr.sv
// Dual-port distributed RAM wrapper with a self-clearing start-up sequence.
// Port A: byte-enabled read/write. Port B: read-only. Both ports are read-first.
// After reset, every word is written to zero, one word per cycle. The ports
// accept traffic only once that sweep has finished (init_done=1).
// READ_LATENCY selects one or two output register stages. The second stage is
// gated by regcea/regceb.
// Optional build macro XPMWRAP_DPDISTRAM_CLR_FWD_EN: a port B read that collides
// with a port A write to the same address returns the freshly written bytes.
module xpmwrap_dpdistram_clr #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                             clka,
  input  logic                             rsta,
  output logic                             init_done,
  input  logic                             ena,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
  input  logic [ADDR_WIDTH-1:0]            addra,
  input  logic [DATA_WIDTH-1:0]            dina,
  input  logic                             regcea,
  output logic [DATA_WIDTH-1:0]            douta,
  output logic                             douta_vld,
  input  logic                             enb,
  input  logic [ADDR_WIDTH-1:0]            addrb,
  input  logic                             regceb,
  output logic [DATA_WIDTH-1:0]            doutb,
  output logic                             doutb_vld
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_ptr;
  logic                    w_ready;
  logic                    w_rda_en;
  logic                    w_rdb_en;
  logic [DATA_WIDTH-1:0]   w_rda;
  logic [DATA_WIDTH-1:0]   w_rdb;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [DATA_WIDTH-1:0]   r_douta_p1;
  logic [DATA_WIDTH-1:0]   r_doutb_p1;
  logic                    r_vlda_p1;
  logic                    r_vldb_p1;

  // State register and clear pointer; the pointer only advances while clearing
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
    end
  end

  // Next state: leave CLEAR right after the last word has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = (r_state == ST_READY);
    if (r_state == ST_CLEAR && r_clr_ptr == LAST_ADDR) w_state_nxt = ST_READY;
  end

  assign init_done = w_ready;
  assign w_rda_en  = w_ready & ena;
  assign w_rdb_en  = w_ready & enb;

  // Memory array: zero sweep during CLEAR, byte-enabled port A writes afterwards
  always_ff @(posedge clka) begin
    if (!rsta) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_ptr] <= '0;
      end else if (ena) begin
        for (int i = 0; i < NB; i++) begin
          if (wea[i]) r_mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  assign w_rda = r_mem[addra];

  // Port B read word, optionally merged with a colliding port A write
  always_comb begin
    w_rdb = r_mem[addrb];
`ifdef XPMWRAP_DPDISTRAM_CLR_FWD_EN
    if (w_ready && ena && (addra == addrb)) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) w_rdb[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
`endif
  end

  // ---- stage 1: array read register; data holds when the port is idle ----
  always_ff @(posedge clka) begin
    if (rsta) begin
      r_douta_p1 <= '0;
      r_doutb_p1 <= '0;
      r_vlda_p1  <= 1'b0;
      r_vldb_p1  <= 1'b0;
    end else begin
      r_vlda_p1 <= w_rda_en;
      r_vldb_p1 <= w_rdb_en;
      if (w_rda_en) r_douta_p1 <= w_rda;
      if (w_rdb_en) r_doutb_p1 <= w_rdb;
    end
  end

  // regcea/regceb have no effect with a single output stage
  logic w_unused;
  assign w_unused = &{1'b0, regcea, regceb};

  if (READ_LATENCY == 1) begin : g_lat1
    assign douta     = r_douta_p1;
    assign douta_vld = r_vlda_p1;
    assign doutb     = r_doutb_p1;
    assign doutb_vld = r_vldb_p1;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] r_douta_p2;
    logic [DATA_WIDTH-1:0] r_doutb_p2;
    logic                  r_vlda_p2;
    logic                  r_vldb_p2;

    // ---- stage 2: output register, data and valid frozen together by regce ----
    always_ff @(posedge clka) begin
      if (rsta) begin
        r_douta_p2 <= '0;
        r_doutb_p2 <= '0;
        r_vlda_p2  <= 1'b0;
        r_vldb_p2  <= 1'b0;
      end else begin
        if (regcea) begin
          r_douta_p2 <= r_douta_p1;
          r_vlda_p2  <= r_vlda_p1;
        end
        if (regceb) begin
          r_doutb_p2 <= r_doutb_p1;
          r_vldb_p2  <= r_vldb_p1;
        end
      end
    end

    assign douta     = r_douta_p2;
    assign douta_vld = r_vlda_p2;
    assign doutb     = r_doutb_p2;
    assign doutb_vld = r_vldb_p2;
  end else begin : g_bad_latency
    $error("xpmwrap_dpdistram_clr: READ_LATENCY must be 1 or 2");
  end

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bytes
    $error("xpmwrap_dpdistram_clr: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

endmodule

// File: tb/tb_xpmwrap_dpdistram_clr.sv
// Directed bench for xpmwrap_dpdistram_clr. It runs one READ_LATENCY=1 instance
// and one READ_LATENCY=2 instance side by side on the same inputs.
module tb_xpmwrap_dpdistram_clr;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int NB = 4;

`ifdef XPMWRAP_DPDISTRAM_CLR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rsta;
  logic          ena, enb, regcea, regceb;
  logic [NB-1:0] wea;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina;

  logic          d1_init, d1_douta_vld, d1_doutb_vld;
  logic [DW-1:0] d1_douta, d1_doutb;
  logic          d2_init, d2_douta_vld, d2_doutb_vld;
  logic [DW-1:0] d2_douta, d2_doutb;

  int n_eval = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xpmwrap_dpdistram_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(1)) dut1 (
    .clka(clk), .rsta(rsta), .init_done(d1_init),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .regcea(regcea),
    .douta(d1_douta), .douta_vld(d1_douta_vld),
    .enb(enb), .addrb(addrb), .regceb(regceb),
    .doutb(d1_doutb), .doutb_vld(d1_doutb_vld));

  xpmwrap_dpdistram_clr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_WIDTH(8), .READ_LATENCY(2)) dut2 (
    .clka(clk), .rsta(rsta), .init_done(d2_init),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .regcea(regcea),
    .douta(d2_douta), .douta_vld(d2_douta_vld),
    .enb(enb), .addrb(addrb), .regceb(regceb),
    .doutb(d2_doutb), .doutb_vld(d2_doutb_vld));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until init_done; every valid output must stay low meanwhile
  task automatic run_clear(input string tag);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    while (!d1_init && n < 200) begin
      step();
      n++;
      if (d1_douta_vld || d1_doutb_vld || d2_douta_vld || d2_doutb_vld) bad++;
    end
    chk({tag, "_cycles"}, n, 64);
    chk({tag, "_vld_quiet"}, bad, 0);
    chk({tag, "_init_lat2"}, {31'd0, d2_init}, 1);
  endtask

  initial begin
    int bad;
    rsta = 1'b1; ena = 1'b0; enb = 1'b0; wea = '0; addra = '0; addrb = '0;
    dina = '0; regcea = 1'b1; regceb = 1'b1;
    step(); step();
    chk("rst_init", {31'd0, d1_init}, 0);
    chk("rst_douta", d1_douta, 0);
    chk("rst_vld", {30'd0, d1_douta_vld, d1_doutb_vld}, 0);
    chk("rst_lat2_vld", {30'd0, d2_douta_vld, d2_doutb_vld}, 0);

    // Traffic during the sweep must be ignored
    rsta = 1'b0; ena = 1'b1; wea = 4'hF; dina = 32'hFFFF_FFFF; addra = 6'd3;
    enb = 1'b1; addrb = 6'd3;
    run_clear("clr1");

    // Every word reads back as zero on both ports
    bad = 0;
    wea = 4'h0;
    for (int a = 0; a < 64; a++) begin
      addra = 6'(a);
      addrb = 6'(63 - a);
      step();
      if (d1_douta !== 0 || d1_doutb !== 0 || !d1_douta_vld || !d1_doutb_vld) bad++;
    end
    chk("all_zero", bad, 0);

    // Full-word write then read on both ports
    ena = 1'b1; wea = 4'hF; addra = 6'd5; dina = 32'hDEAD_BEEF; enb = 1'b0;
    step();
    chk("wr_readfirst_a", d1_douta, 32'h0);
    chk("wr_vld_b_idle", {31'd0, d1_doutb_vld}, 0);
    wea = 4'h0; enb = 1'b1; addrb = 6'd5;
    step();
    chk("rd5_a", d1_douta, 32'hDEAD_BEEF);
    chk("rd5_b", d1_doutb, 32'hDEAD_BEEF);
    chk("rd5_vld", {30'd0, d1_douta_vld, d1_doutb_vld}, 2'b11);
    chk("rd5_lat2_early", {31'd0, d2_doutb_vld}, 0);
    ena = 1'b0; enb = 1'b0;
    step();
    chk("rd5_vld_pulse", {30'd0, d1_douta_vld, d1_doutb_vld}, 0);
    chk("rd5_hold_a", d1_douta, 32'hDEAD_BEEF);
    chk("rd5_lat2_b", d2_doutb, 32'hDEAD_BEEF);
    chk("rd5_lat2_vld", {31'd0, d2_doutb_vld}, 1);
    step();
    chk("rd5_lat2_pulse", {31'd0, d2_doutb_vld}, 0);

    // Byte-lane write
    ena = 1'b1; wea = 4'hF; addra = 6'd9; dina = 32'h1122_3344;
    step();
    wea = 4'b0010; dina = 32'h0000_AB00;
    step();
    chk("byte_readfirst", d1_douta, 32'h1122_3344);
    wea = 4'h0; enb = 1'b1; addrb = 6'd9;
    step();
    chk("byte_a", d1_douta, 32'h1122_AB44);
    chk("byte_b", d1_doutb, 32'h1122_AB44);

    // Same-cycle write on A and read on B of address 7
    wea = 4'hF; addra = 6'd7; dina = 32'hCAFE_F00D; addrb = 6'd7;
    step();
    chk("coll_b", d1_doutb, FWD ? 32'hCAFE_F00D : 32'h0);
    chk("coll_a_readfirst", d1_douta, 32'h0);
    wea = 4'b0001; dina = 32'h0000_00AA;
    step();
    chk("coll_part_b", d1_doutb, FWD ? 32'hCAFE_F0AA : 32'hCAFE_F00D);
    chk("coll_part_a", d1_douta, 32'hCAFE_F00D);
    ena = 1'b0; wea = 4'h0;
    step();
    chk("coll_after_b", d1_doutb, 32'hCAFE_F0AA);

    // Stage-2 freeze on port B
    enb = 1'b0;
    step(); step();
    chk("frz_pre_b", d2_doutb, 32'hCAFE_F0AA);
    chk("frz_pre_vld", {31'd0, d2_doutb_vld}, 0);
    regceb = 1'b0; enb = 1'b1; addrb = 6'd5;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("frz_b", d2_doutb, 32'hCAFE_F0AA);
      chk("frz_vld", {31'd0, d2_doutb_vld}, 0);
    end
    chk("frz_lat1_b", d1_doutb, 32'hDEAD_BEEF);
    regceb = 1'b1;
    step();
    chk("unfrz_b", d2_doutb, 32'hDEAD_BEEF);
    chk("unfrz_vld", {31'd0, d2_doutb_vld}, 1);

    // Reset in the middle of the sweep
    enb = 1'b0;
    rsta = 1'b1;
    step();
    rsta = 1'b0;
    for (int k = 0; k < 30; k++) step();
    chk("midclr_init", {31'd0, d1_init}, 0);
    rsta = 1'b1;
    step();
    chk("midclr_rst_init", {31'd0, d1_init}, 0);
    rsta = 1'b0; ena = 1'b1; wea = 4'hF; dina = 32'hFFFF_FFFF; addra = 6'd3;
    enb = 1'b1; addrb = 6'd3;
    run_clear("clr2");

    // Reset during back-to-back reads
    enb = 1'b0; wea = 4'hF; addra = 6'd5; dina = 32'h1234_5678;
    step();
    wea = 4'h0; enb = 1'b1; addrb = 6'd5;
    step();
    chk("b2b_a", d1_douta, 32'h1234_5678);
    chk("b2b_vld", {30'd0, d1_douta_vld, d1_doutb_vld}, 2'b11);
    step();
    rsta = 1'b1;
    step();
    chk("b2b_rst_vld", {28'd0, d1_douta_vld, d1_doutb_vld, d2_douta_vld, d2_doutb_vld}, 0);
    chk("b2b_rst_a", d1_douta, 32'h0);
    chk("b2b_rst_lat2_b", d2_doutb, 32'h0);
    rsta = 1'b0;
    run_clear("clr3");
    ena = 1'b0; enb = 1'b1; addrb = 6'd5;
    step();
    chk("post_clr_b", d1_doutb, 32'h0);
    chk("post_clr_vld", {31'd0, d1_doutb_vld}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
